// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter slice.
// Data-path widths of mem_req_t follow MEM_ADDR_W / MEM_DATA_W.
package mem_arb_pkg;

  localparam int WORD_SHIFT = 2;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    HOLD
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational one-hot grant picker for mem_arbiter.
// MEM_ARB_RR_EN defined: round-robin search from start; undefined: lowest index wins.
module arb_pick #(
  parameter int N_PORTS = 2,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_valid,
`ifdef MEM_ARB_RR_EN
  input  logic [PTR_W-1:0]   start,
`endif
  output logic [N_PORTS-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  int k;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    for (int i = 0; i < N_PORTS; i++) begin
`ifdef MEM_ARB_RR_EN
      k = int'(start) + i;
      if (k >= N_PORTS) k = k - N_PORTS;
`else
      k = i;
`endif
      if (!any && req_valid[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates N_PORTS requesters onto a single-port, 1-cycle-latency word memory.
// Optional round-robin arbitration with macro MEM_ARB_RR_EN; fixed priority otherwise.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PORTS-1:0]    req_valid,
  input  logic [N_PORTS-1:0]    req_we,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  output logic [N_PORTS-1:0]    req_ready,
  output logic [N_PORTS-1:0]    resp_valid,
  output logic                  resp_is_wr,
  output logic [DATA_W-1:0]     resp_data,
  input  logic [N_PORTS-1:0]    resp_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_r_addr,
  output logic [ADDR_W-1:0]     mem_w_addr,
  output logic [DATA_W-1:0]     mem_w_data,
  input  logic [DATA_W-1:0]     mem_r_data
);

  localparam int PTR_W = $clog2(N_PORTS);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] owner_q;
  logic             is_wr_q;
  logic [DATA_W-1:0] resp_q;

  logic [N_PORTS-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               owner_ready;
  logic               grant_en;
  logic [DATA_W-1:0]  live_data;
  mem_req_t           sel_req;

`ifdef MEM_ARB_RR_EN
  logic [PTR_W-1:0] rr_ptr_q;

  arb_pick #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_pick (
    .req_valid (req_valid),
    .start     (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );
`else
  arb_pick #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_pick (
    .req_valid (req_valid),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );
`endif

  // A new grant may overlap the response of the previous one when its owner takes it.
  assign owner_ready = resp_ready[owner_q];
  assign grant_en    = !rst && pick_any && (state_q == IDLE || owner_ready);
  assign live_data   = is_wr_q ? '0 : mem_r_data;

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        sel_req.we    = req_we[i];
        sel_req.addr  = MEM_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
        sel_req.wdata = MEM_DATA_W'(req_wdata[i*DATA_W +: DATA_W]);
      end
    end
  end

  always_comb begin
    req_ready  = grant_en ? pick_grant : '0;
    mem_we     = grant_en && sel_req.we;
    mem_r_addr = grant_en ? ADDR_W'(sel_req.addr)  : '0;
    mem_w_addr = grant_en ? ADDR_W'(sel_req.addr)  : '0;
    mem_w_data = grant_en ? DATA_W'(sel_req.wdata) : '0;

    resp_valid = '0;
    resp_is_wr = 1'b0;
    resp_data  = '0;
    if (state_q != IDLE) begin
      resp_valid[owner_q] = 1'b1;
      resp_is_wr          = is_wr_q;
      resp_data           = (state_q == RESP) ? live_data : resp_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (grant_en) state_d = RESP;
      RESP, HOLD: begin
        if (owner_ready) state_d = grant_en ? RESP : IDLE;
        else             state_d = HOLD;
      end
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      is_wr_q <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        owner_q <= pick_idx;
        is_wr_q <= sel_req.we;
      end
      // mem_r_data is only valid in the RESP cycle, so a stalled response keeps its own copy.
      if (state_q == RESP && !owner_ready) resp_q <= live_data;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rr_ptr_q <= '0;
    else if (grant_en) rr_ptr_q <= (pick_idx == PTR_W'(N_PORTS - 1)) ? '0 : pick_idx + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a small word memory behind it.
// Expectations follow MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   req_valid = '0, req_we = '0, req_ready, resp_valid, resp_ready = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic            resp_is_wr, mem_we;
  logic [DW-1:0]   resp_data, mem_w_data, mem_r_data;
  logic [AW-1:0]   mem_r_addr, mem_w_addr;

  mem_arbiter #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_is_wr(resp_is_wr), .resp_data(resp_data), .resp_ready(resp_ready),
    .mem_we(mem_we), .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + i;
  endfunction

  // Word memory with registered read: data for r_addr appears the cycle after.
  logic [31:0] mem_arr [MW];
  logic        mem_load = 1'b1;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MW; i++) mem_arr[i] <= init_word(i);
    end else begin
      if (mem_we) mem_arr[mem_w_addr[5:2]] <= mem_w_data;
      mem_r_data <= mem_arr[mem_r_addr[5:2]];
    end
  end

  // Reference model: at most one response outstanding, data fixed at grant time.
  logic [31:0] ref_mem [MW];
  bit          m_busy;
  int          m_owner, m_rr, pend_g;
  bit          m_wr;
  logic [31:0] m_data;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives inputs just after an edge and checks outputs just before the next one.
  task automatic apply(input logic [1:0] v, input logic [1:0] we, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] rr);
    int g;
    int k;
    logic [31:0] ga, gd;
    req_valid = v; req_we = we; req_addr = {a1, a0}; req_wdata = {d1, d0}; resp_ready = rr;
    #8;
    g = -1;
    if (!m_busy || rr[m_owner]) begin
      for (int i = 0; i < NP; i++) begin
`ifdef MEM_ARB_RR_EN
        k = (m_rr + i) % NP;
`else
        k = i;
`endif
        if (g < 0 && v[k]) g = k;
      end
    end
    pend_g = g;
    check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("resp_valid", resp_valid, m_busy ? (64'd1 << m_owner) : 64'd0);
    check("resp_is_wr", resp_is_wr, m_busy ? m_wr : 1'b0);
    if (m_busy) check("resp_data", resp_data, m_data);
    if (g >= 0) begin
      ga = (g == 0) ? a0 : a1;
      gd = (g == 0) ? d0 : d1;
      check("mem_we", mem_we, we[g]);
      check("mem_r_addr", mem_r_addr, ga);
      check("mem_w_addr", mem_w_addr, ga);
      if (we[g]) check("mem_w_data", mem_w_data, gd);
    end else begin
      check("idle_mem_we", mem_we, 0);
      check("idle_mem_addr", {mem_r_addr, mem_w_addr}, 0);
      check("idle_mem_wdata", mem_w_data, 0);
    end
  endtask

  task automatic advance();
    int idx;
    logic [31:0] ga, gd;
    if (m_busy && resp_ready[m_owner]) m_busy = 0;
    if (pend_g >= 0) begin
      ga  = req_addr[pend_g*AW +: AW];
      gd  = req_wdata[pend_g*DW +: DW];
      idx = int'(ga >> WORD_SHIFT) % MW;
      m_busy  = 1;
      m_owner = pend_g;
      m_wr    = req_we[pend_g];
      m_data  = m_wr ? 32'd0 : ref_mem[idx];
      if (m_wr) ref_mem[idx] = gd;
      m_rr = (pend_g + 1) % NP;
    end
    @(posedge clk); #1;
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] rr);
    apply(v, we, a0, a1, d0, d1, rr);
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b01; resp_ready = 2'b11;
    req_addr = {32'h24, 32'h14}; req_wdata = {32'h5555_5555, 32'h1111_1111};
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_is_wr", resp_is_wr, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_bus", {mem_r_addr, mem_w_addr, mem_w_data}, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    m_busy = 0; m_rr = 0; m_owner = 0; pend_g = -1;
  endtask

  typedef struct {
    logic [1:0]  v, we;
    logic [31:0] addr, wdata;
    logic [1:0]  rr;
    logic [1:0]  e_ready, e_rvalid;
    logic        e_wr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] rnd_addr();
    return (32'($urandom_range(0, MW - 1)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [1:0] rr;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    m_busy = 0; m_rr = 0; m_owner = 0; pend_g = -1;

    //            v      we     addr          wdata          rr     ready  rvalid wr    data
    vecs[0]  = '{2'b00, 2'b00, 32'h00, 32'h0,          2'b11, 2'b00, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{2'b01, 2'b00, 32'h10, 32'h0,          2'b11, 2'b01, 2'b00, 1'b0, 32'h0};
    vecs[2]  = '{2'b00, 2'b00, 32'h00, 32'h0,          2'b11, 2'b00, 2'b01, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{2'b10, 2'b10, 32'h20, 32'h1234_5678,  2'b11, 2'b10, 2'b00, 1'b0, 32'h0};
    vecs[4]  = '{2'b10, 2'b00, 32'h20, 32'h0,          2'b11, 2'b10, 2'b10, 1'b1, 32'h0};
    vecs[5]  = '{2'b00, 2'b00, 32'h00, 32'h0,          2'b11, 2'b00, 2'b10, 1'b0, 32'h1234_5678};
    vecs[6]  = '{2'b01, 2'b00, 32'h13, 32'h0,          2'b11, 2'b01, 2'b00, 1'b0, 32'h0};
    vecs[7]  = '{2'b00, 2'b00, 32'h00, 32'h0,          2'b11, 2'b00, 2'b01, 1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{2'b10, 2'b10, 32'h3C, 32'hCAFE_F00D,  2'b00, 2'b10, 2'b00, 1'b0, 32'h0};
    vecs[9]  = '{2'b00, 2'b00, 32'h00, 32'h0,          2'b01, 2'b00, 2'b10, 1'b1, 32'h0};
    vecs[10] = '{2'b01, 2'b00, 32'h10, 32'h0,          2'b01, 2'b00, 2'b10, 1'b1, 32'h0};
    vecs[11] = '{2'b01, 2'b00, 32'h10, 32'h0,          2'b10, 2'b01, 2'b10, 1'b1, 32'h0};
    vecs[12] = '{2'b00, 2'b00, 32'h00, 32'h0,          2'b11, 2'b00, 2'b01, 1'b0, 32'hDEAD_BEEF};

    @(posedge clk); #1;
    mem_load = 1'b0;
    do_reset();

    // Single read, write-then-read, low address bits, non-owner ready ignored.
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].v, vecs[i].we, vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].wdata,
            vecs[i].rr);
      check($sformatf("vec%0d_ready", i), req_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_rvalid", i), resp_valid, vecs[i].e_rvalid);
      check($sformatf("vec%0d_is_wr", i), resp_is_wr, vecs[i].e_wr);
      if (vecs[i].e_rvalid != 0) check($sformatf("vec%0d_data", i), resp_data, vecs[i].e_data);
      advance();
    end

    // Backpressure: response held three cycles, released together with a new grant.
    step(2'b01, 2'b00, 32'h10, 32'h20, 0, 0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      apply(2'b11, 2'b00, 32'h10, 32'h20, 0, 0, 2'b00);
      check("hold_no_ready", req_ready, 0);
      check("hold_data", resp_data, 32'hDEAD_BEEF);
      advance();
    end
    apply(2'b10, 2'b00, 32'h10, 32'h20, 0, 0, 2'b01);
    check("hold_release_ready", req_ready, 2'b10);
    check("hold_release_data", resp_data, 32'hDEAD_BEEF);
    advance();
    apply(2'b00, 2'b00, 0, 0, 0, 0, 2'b11);
    check("after_hold_data", resp_data, 32'h1234_5678);
    advance();

    // Contention from a fresh pointer.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(2'b11, 2'b00, 32'h04, 32'h08, 0, 0, 2'b11);
`ifdef MEM_ARB_RR_EN
      check($sformatf("contend%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check($sformatf("contend%0d", i), req_ready, 2'b01);
`endif
      advance();
    end
    step(2'b00, 2'b00, 0, 0, 0, 0, 2'b11);

    // Reset during the response cycle of a port-1 read.
    step(2'b10, 2'b00, 0, 32'h20, 0, 0, 2'b11);
    rst = 1'b1; req_valid = 2'b11;
    #1;
    check("rst_mid_resp_valid", resp_valid, 0);
    check("rst_mid_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_busy = 0; m_rr = 0; m_owner = 0; pend_g = -1;
    apply(2'b11, 2'b00, 32'h10, 32'h20, 0, 0, 2'b11);
    check("post_rst_grant", req_ready, 2'b01);
    advance();
    step(2'b00, 2'b00, 0, 0, 0, 0, 2'b11);

    // Streaming: eight back-to-back reads answered on consecutive cycles.
    for (int i = 0; i <= 8; i++) begin
      apply((i < 8) ? 2'b01 : 2'b00, 2'b00, 32'(i * 4), 0, 0, 0, 2'b11);
      if (i > 0) begin
        check($sformatf("stream%0d_valid", i - 1), resp_valid, 2'b01);
        check($sformatf("stream%0d_data", i - 1), resp_data, init_word(i - 1));
      end
      advance();
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rr[0] = ($urandom_range(0, 3) != 0);
      rr[1] = ($urandom_range(0, 3) != 0);
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rnd_addr(), rnd_addr(),
           $urandom, $urandom, rr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
